// File: rtl/serial_word_tx.sv
// LSB-first parallel-to-serial transmitter with generated shift clock and
// full-duplex capture of the returning sdi line into rx_data.
module serial_word_tx #(
    parameter int WIDTH = 31,
    parameter int DIV   = 4
) (
    input  logic             qzt_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             sdi,
    output logic             sclk,
    output logic             sdo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic [1:0]       state_dbg
);

    // Handshake: start is taken only in a cycle where busy=0 (including the
    // done cycle); done pulses for one cycle and rx_data is valid from then on.

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    div_cnt, div_cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] tx_sr, tx_sr_n;
    logic [WIDTH-1:0] rx_sr, rx_sr_n;
    logic [WIDTH-1:0] rx_data_n;
    logic             sclk_n, sdo_n, busy_n, done_n;

    assign state_dbg = state;

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            tx_sr   <= tx_sr_n;
            rx_sr   <= rx_sr_n;
            rx_data <= rx_data_n;
            sclk    <= sclk_n;
            sdo     <= sdo_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        bit_cnt_n = bit_cnt;
        tx_sr_n   = tx_sr;
        rx_sr_n   = rx_sr;
        rx_data_n = rx_data;
        sclk_n    = sclk;
        sdo_n     = sdo;
        busy_n    = busy;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                sclk_n = 1'b0;
                sdo_n  = 1'b0;
                busy_n = 1'b0;
                if (start) begin
                    tx_sr_n   = tx_data;
                    rx_sr_n   = '0;
                    bit_cnt_n = '0;
                    div_cnt_n = '0;
                    sdo_n     = tx_data[0];
                    busy_n    = 1'b1;
                    state_n   = LOW;
                end
            end
            LOW: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    sclk_n    = 1'b1;
                    state_n   = HIGH;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            HIGH: begin
                if (div_cnt == DIV_LAST) begin
                    // Receivers shift on the rising edge; we sample sdi at the
                    // last high cycle so the far end has had DIV cycles to settle.
                    div_cnt_n = '0;
                    rx_sr_n   = {sdi, rx_sr[WIDTH-1:1]};
                    sclk_n    = 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        rx_data_n = {sdi, rx_sr[WIDTH-1:1]};
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        sdo_n     = 1'b0;
                        state_n   = IDLE;
                    end else begin
                        tx_sr_n   = {1'b0, tx_sr[WIDTH-1:1]};
                        sdo_n     = tx_sr[1];
                        bit_cnt_n = bit_cnt + 1'b1;
                        state_n   = LOW;
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: transaction-level model checked every cycle,
// directed timing/loopback scenarios, then randomized traffic.
module tb_serial_word_tx;

    localparam int W = 31;
    localparam int D = 4;

    // clock / reset
    logic qzt_clk = 1'b0;
    always #5 qzt_clk = ~qzt_clk;

    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         sdi;
    logic         sclk, sdo, busy, done;
    logic [W-1:0] rx_data;
    logic [1:0]   state_dbg;

    bit           loopback = 1'b1;
    logic         sdi_rand = 1'b0;
    assign sdi = loopback ? sdo : sdi_rand;

    serial_word_tx #(.WIDTH(W), .DIV(D)) dut (
        .qzt_clk  (qzt_clk),
        .reset    (reset),
        .start    (start),
        .tx_data  (tx_data),
        .sdi      (sdi),
        .sclk     (sclk),
        .sdo      (sdo),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .state_dbg(state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a transfer is just "word, started at t=0";
    // outputs at relative cycle t follow from arithmetic on t.
    bit           m_active = 1'b0;
    int           m_t = 0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_rx = '0;
    logic [W-1:0] e_rx = '0;
    bit           e_done = 1'b0;

    always @(posedge qzt_clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_t      = 0;
            e_done   = 1'b0;
            e_rx     = '0;
        end else if (m_active) begin
            if (m_t % (2 * D) == 0) begin
                int k;
                k = m_t / (2 * D) - 1;
                m_rx[k] = loopback ? m_word[k] : sdi_rand;
            end
            if (m_t == 2 * D * W) begin
                m_active = 1'b0;
                e_rx     = m_rx;
                e_done   = 1'b1;
            end else begin
                m_t++;
            end
        end else begin
            e_done = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_t      = 1;
                m_word   = tx_data;
                m_rx     = '0;
            end
        end
    end

    // scoreboard compare on the falling edge
    always @(negedge qzt_clk) begin
        if (chk_en) begin
            logic e_sclk, e_sdo;
            e_sclk = m_active && (((m_t - 1) % (2 * D)) >= D);
            e_sdo  = m_active ? m_word[(m_t - 1) / (2 * D)] : 1'b0;
            check("cycle_outputs", {sclk, sdo, busy, done, rx_data},
                  {e_sclk, e_sdo, m_active, e_done, e_rx});
        end
    end

    // driver tasks
    task automatic cyc_step();
        @(posedge qzt_clk);
        #1;
    endtask

    int           s_rises, s_first_rise, s_last_rise, s_bad_gap;
    int           s_dones, s_done1, s_done2, s_busy_low, s_bad_rx;
    bit           s_busy1;
    logic [W-1:0] s_recv;

    // Start at cycle 0, then observe ncyc cycles while an external
    // rising-edge receiver listens on sclk/sdo.
    task automatic run(input int ncyc, input logic [W-1:0] word, input bit hold,
                       input int poke_at, input logic [W-1:0] poke_word, input int rst_at);
        logic prev_sclk;
        s_rises = 0; s_first_rise = -1; s_last_rise = -1; s_bad_gap = 0;
        s_dones = 0; s_done1 = -1; s_done2 = -1; s_busy_low = 0; s_bad_rx = 0;
        s_busy1 = 1'b0; s_recv = '0;
        prev_sclk = sclk;
        tx_data = word;
        start = 1'b1;
        reset = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            cyc_step();
            if (!hold) start = 1'b0;
            if (n == poke_at) begin
                start = 1'b1;
                tx_data = poke_word;
            end
            reset = (n == rst_at);
            if (n == 1) s_busy1 = busy;
            if (rst_at >= 0 && n == rst_at + 1)
                check("reset_abort", {sclk, sdo, busy, done, rx_data}, '0);
            if (sclk && !prev_sclk) begin
                if (s_rises > 0 && n - s_last_rise != 2 * D) s_bad_gap++;
                if (s_rises == 0) s_first_rise = n;
                s_last_rise = n;
                s_rises++;
                s_recv = {sdo, s_recv[W-1:1]};
            end
            if (done) begin
                s_dones++;
                if (s_dones == 1) s_done1 = n;
                if (s_dones == 2) s_done2 = n;
                if (rx_data !== word) s_bad_rx++;
            end
            if (!busy && !done) s_busy_low++;
            prev_sclk = sclk;
        end
        start = 1'b0;
    endtask

    initial begin
        // 1. reset held with start=1
        tx_data = 31'h2BADCAFE;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc_step();
            chk_en = 1'b1;
            check("reset_idle", {sclk, sdo, busy, done, rx_data}, '0);
        end
        reset = 1'b0;
        start = 1'b0;
        cyc_step();
        check("post_reset_idle", {sclk, busy, done}, '0);

        // 2. loopback timing
        run(260, 31'h12345678, 1'b0, -1, '0, -1);
        check("t2_busy_c1", 64'(s_busy1), 64'd1);
        check("t2_rises", 64'(s_rises), 64'd31);
        check("t2_first_rise", 64'(s_first_rise), 64'd5);
        check("t2_last_rise", 64'(s_last_rise), 64'd245);
        check("t2_gap", 64'(s_bad_gap), 64'd0);
        check("t2_dones", 64'(s_dones), 64'd1);
        check("t2_done_cyc", 64'(s_done1), 64'd249);
        check("t2_rx", 64'(rx_data), 64'h12345678);
        check("t2_model_rx", 64'(e_rx), 64'h12345678);

        // 3. external shift-register receiver
        run(252, 31'h40000001, 1'b0, -1, '0, -1);
        check("t3_recv", 64'(s_recv), 64'h40000001);
        check("t3_rx", 64'(rx_data), 64'h40000001);
        check("t3_done_cyc", 64'(s_done1), 64'd249);

        // 4. start while busy ignored
        run(260, 31'h0000000F, 1'b0, 50, 31'h7FFFFFFF, -1);
        check("t4_dones", 64'(s_dones), 64'd1);
        check("t4_done_cyc", 64'(s_done1), 64'd249);
        check("t4_rx", 64'(rx_data), 64'h0000000F);

        // 5. reset mid-transfer, then a clean transfer
        run(300, 31'h3C3C3C3C, 1'b0, -1, '0, 100);
        check("t5_no_done", 64'(s_dones), 64'd0);
        run(252, 31'h2468ACE1, 1'b0, -1, '0, -1);
        check("t5_done_cyc", 64'(s_done1), 64'd249);
        check("t5_rx", 64'(rx_data), 64'h2468ACE1);

        // 6. start held high: back-to-back
        run(500, 31'h55555555, 1'b1, -1, '0, -1);
        check("t6_dones", 64'(s_dones), 64'd2);
        check("t6_done1", 64'(s_done1), 64'd249);
        check("t6_done2", 64'(s_done2), 64'd498);
        check("t6_busy_gap", 64'(s_busy_low), 64'd0);
        check("t6_rx", 64'(s_bad_rx), 64'd0);
        for (int i = 0; i < 260; i++) cyc_step();

        // randomized traffic with independent sdi and rare resets
        loopback = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            sdi_rand = 1'($urandom_range(0, 1));
            start    = ($urandom_range(0, 9) == 0);
            tx_data  = W'($urandom);
            reset    = ($urandom_range(0, 999) == 0);
            cyc_step();
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 260; i++) cyc_step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter (bus master) for the lab serial link.
- Takes a WIDTH-bit word and generates its own shift clock (sclk) from qzt_clk. Shifts the word out LSB-first on sdo.
- Captures the returning sdi line into rx_data, so the far end's word is read back (full duplex).
- Drives the external shift-register receivers, which sample data on the sclk rising edge.

Parameters:
WIDTH, 31, word length in bits (>=2)
DIV, 4, qzt_clk cycles per sclk half-period (>=1)

Ports:
qzt_clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high
start  input  1  request transfer; sampled only when busy=0
tx_data  input  WIDTH  word to send; latched in the cycle start is accepted
sdi  input  1  serial return data, synchronous to qzt_clk
sclk  output  1  generated shift clock, idle low
sdo  output  1  serial data out, LSB first
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse when a transfer completes
rx_data  output  WIDTH  last received word, valid from the done cycle

Behaviour:
- Clocking and reset: reset and clock are fixed as reset (synchronous, active-high) and qzt_clk. No other clocks.
- Reset values: sclk=0, sdo=0, busy=0, done=0, rx_data=0; state=IDLE; all counters=0.
- Reset has priority over every event. Asserting it mid-transfer aborts at once: no done pulse, rx_data cleared.
- State machine: IDLE, LOW, HIGH.
- IDLE:
  - start=1 at cycle 0 latches tx_data into tx_sr and clears bit_cnt and div_cnt.
  - Next cycle (cycle 1): busy=1, sdo=tx_data[0], sclk=0, state LOW.
  - start=0 keeps all outputs at idle values.
- LOW:
  - sclk=0 for DIV cycles; sdo stable (setup time).
  - After DIV cycles: sclk=1, state HIGH.
- HIGH:
  - sclk=1 for DIV cycles.
  - In the last HIGH cycle, sdi is sampled: rx_sr = {sdi, rx_sr[WIDTH-1:1]}. This is a right shift with sdi entering the MSB, matching the receiver convention.
  - Same edge, sclk goes to 0.
- End of HIGH, bit_cnt<WIDTH-1:
  - tx_sr shifts right and sdo takes the next bit.
  - bit_cnt increments; state LOW.
- End of HIGH, bit_cnt==WIDTH-1:
  - rx_data=final rx_sr, done=1, busy=0, sdo=0, sclk=0; state IDLE.
- Timing:
  - Bit k is on sdo from cycle 1+2*DIV*k.
  - sclk rises at 1+2*DIV*k+DIV and falls at 1+2*DIV*(k+1).
  - done is asserted at cycle 1+2*DIV*WIDTH (249 for defaults).
  - Exactly WIDTH sclk rising edges per transfer.
- start while busy=1: ignored, not queued. tx_data changes while busy: no effect.
- start=1 in the done cycle is accepted (busy=0). Back-to-back transfers therefore have a one-cycle idle gap, sclk low throughout.
- done lasts exactly one cycle; rx_data holds until the next done or reset.
- sdi is treated as synchronous to qzt_clk; no synchronizer inside. The far end must update its output within DIV cycles of the sclk rising edge.
- Counters:
  - div_cnt spans 0..DIV-1 and wraps.
  - bit_cnt width is ceil(log2(WIDTH)) bits and never exceeds WIDTH-1.

Test Plan:
1. Reset: hold reset for 3 cycles with start=1 -> sclk=0, sdo=0, busy=0, done=0, rx_data=0 throughout; no transfer starts until reset deasserts.
2. Loopback (sdo->sdi), tx_data=31'h12345678, start pulse at cycle 0 ->
   - busy high from cycle 1;
   - 31 sclk rising edges, each 8 cycles apart;
   - done=1 only at cycle 249;
   - rx_data=31'h12345678.
3. Receiver model: a 31-bit right-shift register (input into MSB, shifting on sclk rising edge) driven by sclk/sdo, tx_data=31'h40000001. After done, the model holds 31'h40000001. sdo=1 during bit 0 and bit 30 only.
4. Start while busy: start pulse at cycle 0, tx_data=31'h0000000F; start again at cycle 50 with tx_data=31'h7FFFFFFF ->
   - only one transfer, one done at cycle 249;
   - loopback rx_data=31'h0000000F.
5. Reset mid-transfer: reset at cycle 100 ->
   - next cycle sclk=0, sdo=0, busy=0, rx_data=0;
   - no done;
   - a new start after release completes normally 249 cycles later.
6. start held high, tx_data=31'h55555555 ->
   - done at cycles 249 and 498;
   - busy low only in the done cycles;
   - each loopback rx_data=31'h55555555.
